dsp_pair_scheduler: RTL and testbench
=====================================

# dsp_pair_scheduler

Issue controller for the two-multiplier/one-adder DSP block. Arbitrates between two requester ports and drives the block's operand and mode inputs with the correct pipeline alignment. Captures the 72-bit result into a credit-protected response FIFO and returns it with the requester id. Sits directly in front of the DSP block and shares one block between two clients at one operation per cycle.

## Interface
- RSP_DEPTH, 4: response FIFO entries and maximum outstanding operations. Power of two, minimum 2.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high. The DSP block's reset is tied to the same net.
- reqN_valid  in  1  request from requester N, N = 0 or 1.
- reqN_ready  out  1  request accepted on this cycle.
- reqN_op  in  2  operation code.
- reqN_a0, reqN_b0, reqN_a1, reqN_b1  in  18 each  unsigned operands.
- dsp_a0, dsp_b0, dsp_a1, dsp_b1  out  18 each  registered operands to the DSP block.
- dsp_mode_0, dsp_mode_1  out  1 each  registered mode to the DSP block.
- dsp_p  in  72  DSP block result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  requester that issued the operation.
- rsp_op  out  2  echoed operation code.
- rsp_data  out  72  result.

## Operation
- Op codes use {mode_1, mode_0} encoding.
  - OP_SUM = 00: result is {35'd0, a0*b0 + a1*b1} (37-bit sum).
  - OP_DUAL = 01: result is {a0*b0, a1*b1}.
  - OP_SINGLE = 10: result is {36'd0, a0*b0}.
  - Code 11 is forwarded unchanged and yields the OP_SINGLE result.
- Handshake:
  - A request transfers when valid && ready.
  - Requesters hold valid, op and operands stable until ready.
  - ready is never asserted for a requester whose valid is low.
- Credit:
  - outstanding = accepted and not yet popped.
  - It increments on accept and decrements on the rsp handshake.
  - Issue is allowed when outstanding < RSP_DEPTH, or when rsp_valid && rsp_ready in the same cycle.
  - This makes reqN_ready combinationally dependent on rsp_ready.
- Arbitration is round-robin with a 1-bit priority pointer.
  - When issue is allowed, the pointed-to requester is granted if it is valid; otherwise the other requester is granted if valid.
  - After any grant, the pointer moves to the non-granted requester.
  - At most one grant per cycle.
- Mode alignment:
  - The DSP registers operands one edge after the controller drives them.
  - The DSP applies the mode at the following edge.
  - The controller therefore drives the mode one cycle after the operands, from a pipeline stage.
- Idle cycles:
  - Operand outputs are driven to 0.
  - Mode outputs hold 00.
- Tracking pipeline:
  - A valid/id/op shift register with stages s0 (operands driven), s1 (mode driven) and s2 (dsp_p valid).
  - s2 writes {id, op, dsp_p} into the FIFO.
- The FIFO never overflows, because credit bounds the total. An overflow is an assertion failure.
- Responses are returned in acceptance order.
- Reset, including mid-operation:
  - All in-flight and buffered operations are discarded.
  - Outputs return to reset values on the next edge.
  - The pointer returns to requester 0.

## Timing
- Reset values: reqN_ready 0, all dsp_* 0, rsp_valid 0, rsp_id 0, rsp_op 00, rsp_data 0, outstanding 0.
- Pipeline, for an accept at edge E0:
  - Operands are registered at E0.
  - The DSP input registers load at E1.
  - The mode is valid between E1 and E2.
  - dsp_p is valid after E2.
  - The FIFO is written at E3.
  - rsp_valid is high after E3, provided the FIFO was empty.
- Latency from accept to rsp_valid is 3 cycles.
- Throughput is 1 operation per cycle sustained when rsp_ready = 1 and RSP_DEPTH ≥ 4.
- Simultaneous FIFO write and pop are both performed, and the count is unchanged.
- The FIFO output is show-ahead: rsp_data is valid whenever rsp_valid is high.

## Structure
- Package dsp_sched_pkg holds:
  - the op_t enum (OP_SUM, OP_DUAL, OP_SINGLE);
  - OPERAND_W = 18, RESULT_W = 72;
  - DSP_LAT = 2, the controller-to-result pipeline stages.
- One sub-module, dsp_rsp_fifo: a synchronous FIFO, RSP_DEPTH × 75 bits, with count output.
- The arbiter, credit counter and tracking pipeline stay in the top level.

## Test plan
- req0 OP_SINGLE with a0=3, b0=5 and rsp_ready=1 -> rsp_valid exactly 3 cycles after accept, rsp_data=15, rsp_id=0, rsp_op=10.
- req1 OP_SUM with a0=2, b0=3, a1=4, b1=5 -> rsp_data=26, rsp_id=1.
- req0 OP_DUAL with a0=b0=18'h3FFFF, a1=7, b1=9 -> rsp_data = {36'hFFFF80001, 36'd63}.
- Both requesters continuously valid with rsp_ready=1:
  - grants alternate 0,1,0,1;
  - one accept per cycle;
  - response ids alternate in the same order.
- Back-to-back SUM, DUAL, SINGLE, SUM with distinct operands -> every result matches its own op. This checks the mode/operand alignment.
- rsp_ready=0 with both requesters valid:
  - exactly 4 accepts, then both ready stay 0;
  - raise rsp_ready -> an accept occurs in the same cycle as the first pop;
  - data arrives in order.
- reset asserted for 1 cycle with 3 operations in flight -> rsp_valid=0 after the edge, and no stale response ever appears after release.

Source files
------------

// File: rtl/dsp_sched_pkg.sv
// Shared definitions for the DSP pair scheduler.
// Contents:
//   op_t        operation codes in {mode_1, mode_0} form.
//   OPERAND_W   DSP operand width.
//   RESULT_W    DSP result width.
//   DSP_LAT     stages between driving the operands and dsp_p being valid.
//   rsp_entry_t one response FIFO entry: {id, op, data}.
package dsp_sched_pkg;

  localparam int OPERAND_W = 18;
  localparam int RESULT_W  = 72;
  localparam int DSP_LAT   = 2;

  typedef enum logic [1:0] {
    OP_SUM    = 2'b00,
    OP_DUAL   = 2'b01,
    OP_SINGLE = 2'b10
  } op_t;

  typedef struct packed {
    logic                id;
    logic [1:0]          op;
    logic [RESULT_W-1:0] data;
  } rsp_entry_t;

  localparam int RSP_W = $bits(rsp_entry_t);

endpackage

// File: rtl/dsp_rsp_fifo.sv
// Synchronous show-ahead response FIFO.
// Ports:
//   clk, reset        clock and synchronous active-high reset.
//   wr_en, wr_data    push one entry.
//   rd_en             pop the head entry (ignored when empty).
//   rd_data           head entry; zero when the FIFO is empty.
//   count             number of stored entries, 0..DEPTH.
module dsp_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 75
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_rd;
  logic             do_wr;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Credit upstream bounds occupancy, so this can only fire on a credit bug.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(wr_en && full && !do_rd));
    end
  end

endmodule

// File: rtl/dsp_pair_scheduler.sv
// Issue controller sharing one two-multiplier/one-adder DSP block between
// two requesters at up to one operation per cycle.
// Ports:
//   clk, reset                  clock and synchronous active-high reset.
//   reqN_valid/ready/op/a0..b1  requester N request channel (N = 0, 1).
//   dsp_a0..dsp_b1              registered operands to the DSP block.
//   dsp_mode_0/1                registered mode, one cycle behind operands.
//   dsp_p                       DSP result, valid DSP_LAT cycles after operands.
//   rsp_valid/ready/id/op/data  show-ahead response channel, acceptance order.
module dsp_pair_scheduler
  import dsp_sched_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [1:0]           req0_op,
  input  logic [OPERAND_W-1:0] req0_a0,
  input  logic [OPERAND_W-1:0] req0_b0,
  input  logic [OPERAND_W-1:0] req0_a1,
  input  logic [OPERAND_W-1:0] req0_b1,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [1:0]           req1_op,
  input  logic [OPERAND_W-1:0] req1_a0,
  input  logic [OPERAND_W-1:0] req1_b0,
  input  logic [OPERAND_W-1:0] req1_a1,
  input  logic [OPERAND_W-1:0] req1_b1,
  output logic [OPERAND_W-1:0] dsp_a0,
  output logic [OPERAND_W-1:0] dsp_b0,
  output logic [OPERAND_W-1:0] dsp_a1,
  output logic [OPERAND_W-1:0] dsp_b1,
  output logic                 dsp_mode_0,
  output logic                 dsp_mode_1,
  input  logic [RESULT_W-1:0]  dsp_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [1:0]           rsp_op,
  output logic [RESULT_W-1:0]  rsp_data
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic          ptr;
  logic          pop;
  logic          issue_ok;
  logic          grant0;
  logic          grant1;
  logic          grant;

  // Tracking pipeline: index 0 = operands driven, DSP_LAT = dsp_p valid.
  logic [DSP_LAT:0] pipe_vld;
  logic [DSP_LAT:0] pipe_id;
  logic [1:0]       pipe_op [DSP_LAT+1];

  rsp_entry_t fifo_wr;
  rsp_entry_t fifo_head;

  // A pop in the same cycle frees a credit, so a full pipeline keeps streaming.
  assign pop      = rsp_valid && rsp_ready;
  assign issue_ok = !reset && ((outstanding < CW'(RSP_DEPTH)) || pop);

  assign grant0 = issue_ok && req0_valid && (!ptr || !req1_valid);
  assign grant1 = issue_ok && req1_valid && (ptr || !req0_valid);
  assign grant  = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= 1'b0;
      outstanding <= '0;
    end else begin
      if (grant0)      ptr <= 1'b1;
      else if (grant1) ptr <= 1'b0;
      case ({grant, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Operands go out on the accept edge; idle cycles drive zeros.
  always_ff @(posedge clk) begin
    if (reset || !grant) begin
      dsp_a0 <= '0;
      dsp_b0 <= '0;
      dsp_a1 <= '0;
      dsp_b1 <= '0;
    end else if (grant1) begin
      dsp_a0 <= req1_a0;
      dsp_b0 <= req1_b0;
      dsp_a1 <= req1_a1;
      dsp_b1 <= req1_b1;
    end else begin
      dsp_a0 <= req0_a0;
      dsp_b0 <= req0_b0;
      dsp_a1 <= req0_a1;
      dsp_b1 <= req0_b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
      for (int i = 0; i <= DSP_LAT; i++) pipe_op[i] <= 2'b00;
    end else begin
      pipe_vld[0] <= grant;
      pipe_id[0]  <= grant1;
      pipe_op[0]  <= grant1 ? req1_op : (grant0 ? req0_op : 2'b00);
      for (int i = 1; i <= DSP_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
        pipe_op[i]  <= pipe_op[i-1];
      end
    end
  end

  // The DSP latches operands one edge later and applies mode the edge after,
  // so the mode comes from stage 0 rather than alongside the operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      dsp_mode_0 <= 1'b0;
      dsp_mode_1 <= 1'b0;
    end else begin
      dsp_mode_0 <= pipe_vld[0] && pipe_op[0][0];
      dsp_mode_1 <= pipe_vld[0] && pipe_op[0][1];
    end
  end

  assign fifo_wr.id   = pipe_id[DSP_LAT];
  assign fifo_wr.op   = pipe_op[DSP_LAT];
  assign fifo_wr.data = dsp_p;

  dsp_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pipe_vld[DSP_LAT]),
    .wr_data (fifo_wr),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);
  assign rsp_id    = fifo_head.id;
  assign rsp_op    = fifo_head.op;
  assign rsp_data  = fifo_head.data;

endmodule

// File: tb/tb_dsp_pair_scheduler.sv
// Scoreboard bench for dsp_pair_scheduler with a behavioural DSP block model.
module tb_dsp_pair_scheduler;
  import dsp_sched_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [17:0] req0_a0, req0_b0, req0_a1, req0_b1;
  logic [17:0] req1_a0, req1_b0, req1_a1, req1_b1;
  logic [17:0] dsp_a0, dsp_b0, dsp_a1, dsp_b1;
  logic        dsp_mode_0, dsp_mode_1;
  logic [71:0] dsp_p;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [1:0]  rsp_op;
  logic [71:0] rsp_data;

  dsp_pair_scheduler #(.RSP_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a0(req0_a0), .req0_b0(req0_b0), .req0_a1(req0_a1), .req0_b1(req0_b1),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a0(req1_a0), .req1_b0(req1_b0), .req1_a1(req1_a1), .req1_b1(req1_b1),
    .dsp_a0(dsp_a0), .dsp_b0(dsp_b0), .dsp_a1(dsp_a1), .dsp_b1(dsp_b1),
    .dsp_mode_0(dsp_mode_0), .dsp_mode_1(dsp_mode_1), .dsp_p(dsp_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_op(rsp_op), .rsp_data(rsp_data)
  );

  // DSP block stand-in: operand registers, then mode applied on the next edge.
  logic [17:0] ra0, rb0, ra1, rb1;

  function automatic logic [71:0] dsp_fn(input logic [1:0] m, input logic [17:0] a0,
                                         input logic [17:0] b0, input logic [17:0] a1,
                                         input logic [17:0] b1);
    logic [35:0] p0, p1;
    p0 = 36'(a0) * 36'(b0);
    p1 = 36'(a1) * 36'(b1);
    case (m)
      2'b00:   return {35'd0, 37'(p0) + 37'(p1)};
      2'b01:   return {p0, p1};
      default: return {36'd0, p0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      ra0 <= '0; rb0 <= '0; ra1 <= '0; rb1 <= '0;
      dsp_p <= '0;
    end else begin
      ra0 <= dsp_a0; rb0 <= dsp_b0; ra1 <= dsp_a1; rb1 <= dsp_b1;
      dsp_p <= dsp_fn({dsp_mode_1, dsp_mode_0}, ra0, rb0, ra1, rb1);
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [17:0] a0, b0, a1, b1;
    logic [71:0] exp;
  } req_t;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [71:0] data;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  req_t q0[$];
  req_t q1[$];
  exp_t sb[$];
  logic acc_ids[$];
  int   acc_cycs[$];
  int   acc_cnt = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Requester driver: notes accepts just before the edge, presents the next
  // vector just after it.  Accept cycle stored is the edge index of the accept.
  req_t cur0, cur1;
  bit   g0, g1;
  always begin
    @(negedge clk);
    g0 = req0_valid && req0_ready;
    g1 = req1_valid && req1_ready;
    if (g0) begin
      sb.push_back('{1'b0, cur0.op, cur0.exp, cyc + 1, lat_chk});
      acc_ids.push_back(1'b0); acc_cycs.push_back(cyc); acc_cnt++;
    end
    if (g1) begin
      sb.push_back('{1'b1, cur1.op, cur1.exp, cyc + 1, lat_chk});
      acc_ids.push_back(1'b1); acc_cycs.push_back(cyc); acc_cnt++;
    end
    @(posedge clk);
    #1;
    if (g0) req0_valid = 1'b0;
    if (g1) req1_valid = 1'b0;
    if (!req0_valid && q0.size() > 0) begin
      cur0 = q0.pop_front();
      req0_op = cur0.op; req0_a0 = cur0.a0; req0_b0 = cur0.b0;
      req0_a1 = cur0.a1; req0_b1 = cur0.b1; req0_valid = 1'b1;
    end
    if (!req1_valid && q1.size() > 0) begin
      cur1 = q1.pop_front();
      req1_op = cur1.op; req1_a0 = cur1.a0; req1_b0 = cur1.b0;
      req1_a1 = cur1.a1; req1_b1 = cur1.b1; req1_valid = 1'b1;
    end
  end

  // Response monitor.
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else if (rsp_valid && rsp_ready) begin
      chk("rsp_expected", 72'(sb.size() != 0), 72'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", 72'(rsp_id), 72'(e.id));
        chk("rsp_op", 72'(rsp_op), 72'(e.op));
        chk("rsp_data", rsp_data, e.data);
        if (e.lat) chk("latency", 72'(cyc - e.acc_cyc), 72'd3);
      end
    end
  end

  task automatic wait_idle(input string nm, input int budget);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      @(posedge clk);
      #2;
      idle = (q0.size() == 0) && (q1.size() == 0) && !req0_valid && !req1_valid &&
             (sb.size() == 0);
      n++;
    end
    chk(nm, 72'(idle), 72'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int s;
  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 2'b00; req0_a0 = '0; req0_b0 = '0; req0_a1 = '0; req0_b1 = '0;
    req1_op = 2'b00; req1_a0 = '0; req1_b0 = '0; req1_a1 = '0; req1_b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req0_ready", 72'(req0_ready), 72'd0);
    chk("rst_req1_ready", 72'(req1_ready), 72'd0);
    chk("rst_dsp_a0", 72'(dsp_a0), 72'd0);
    chk("rst_dsp_b0", 72'(dsp_b0), 72'd0);
    chk("rst_dsp_a1", 72'(dsp_a1), 72'd0);
    chk("rst_dsp_b1", 72'(dsp_b1), 72'd0);
    chk("rst_dsp_mode", 72'({dsp_mode_1, dsp_mode_0}), 72'd0);
    chk("rst_rsp_valid", 72'(rsp_valid), 72'd0);
    chk("rst_rsp_id", 72'(rsp_id), 72'd0);
    chk("rst_rsp_op", 72'(rsp_op), 72'd0);
    chk("rst_rsp_data", rsp_data, 72'd0);
    reset = 1'b0;

    // Single ops from each port, with latency checks.
    lat_chk = 1'b1;
    q0.push_back('{OP_SINGLE, 18'd3, 18'd5, 18'd0, 18'd0, 72'd15});
    wait_idle("single_done", 40);
    q1.push_back('{OP_SUM, 18'd2, 18'd3, 18'd4, 18'd5, 72'd26});
    wait_idle("sum_done", 40);
    q0.push_back('{OP_DUAL, 18'h3FFFF, 18'h3FFFF, 18'd7, 18'd9,
                   {36'hFFFF80001, 36'd63}});
    wait_idle("dual_done", 40);

    // Back-to-back mixed ops: mode must line up with its own operands.
    q0.push_back('{OP_SUM,    18'd1,   18'd2,   18'd3,   18'd4,   72'd14});
    q0.push_back('{OP_DUAL,   18'd5,   18'd6,   18'd7,   18'd8,   {36'd30, 36'd56}});
    q0.push_back('{OP_SINGLE, 18'd9,   18'd10,  18'd11,  18'd12,  72'd90});
    q0.push_back('{OP_SUM,    18'd100, 18'd200, 18'd300, 18'd400, 72'd140000});
    q0.push_back('{2'b11,     18'd6,   18'd7,   18'd8,   18'd9,   72'd42});
    wait_idle("b2b_done", 60);

    // Both requesters saturated after reset: strict alternation from port 0.
    pulse_reset();
    s = acc_ids.size();
    q0.push_back('{OP_SINGLE, 18'd1, 18'd3, 18'd0, 18'd0, 72'd3});
    q0.push_back('{OP_SINGLE, 18'd2, 18'd3, 18'd0, 18'd0, 72'd6});
    q0.push_back('{OP_SINGLE, 18'd3, 18'd3, 18'd0, 18'd0, 72'd9});
    q0.push_back('{OP_SINGLE, 18'd4, 18'd3, 18'd0, 18'd0, 72'd12});
    q1.push_back('{OP_DUAL,   18'd11, 18'd1, 18'd2, 18'd2, {36'd11, 36'd4}});
    q1.push_back('{OP_SUM,    18'd12, 18'd1, 18'd3, 18'd3, 72'd21});
    q1.push_back('{OP_DUAL,   18'd13, 18'd1, 18'd4, 18'd4, {36'd13, 36'd16}});
    q1.push_back('{OP_SINGLE, 18'd14, 18'd1, 18'd0, 18'd0, 72'd14});
    wait_idle("alt_done", 60);
    chk("alt_count", 72'(acc_ids.size() - s), 72'd8);
    if (acc_ids.size() - s == 8) begin
      for (int i = 0; i < 8; i++) chk("alt_id", 72'(acc_ids[s+i]), 72'(i % 2));
      for (int i = 1; i < 8; i++)
        chk("alt_cyc_step", 72'(acc_cycs[s+i] - acc_cycs[s+i-1]), 72'd1);
    end

    // Back-pressure: credit limits to 4, then a pop frees a slot in the same cycle.
    lat_chk = 1'b0;
    rsp_ready = 1'b0;
    s = acc_cnt;
    q0.push_back('{OP_SINGLE, 18'd1,  18'd2, 18'd0, 18'd0, 72'd2});
    q0.push_back('{OP_SINGLE, 18'd2,  18'd2, 18'd0, 18'd0, 72'd4});
    q0.push_back('{OP_SINGLE, 18'd3,  18'd2, 18'd0, 18'd0, 72'd6});
    q1.push_back('{OP_SINGLE, 18'd10, 18'd3, 18'd0, 18'd0, 72'd30});
    q1.push_back('{OP_SINGLE, 18'd20, 18'd3, 18'd0, 18'd0, 72'd60});
    q1.push_back('{OP_SINGLE, 18'd30, 18'd3, 18'd0, 18'd0, 72'd90});
    repeat (12) @(posedge clk);
    #4;
    chk("bp_accepts", 72'(acc_cnt - s), 72'd4);
    chk("bp_req0_ready", 72'(req0_ready), 72'd0);
    chk("bp_req1_ready", 72'(req1_ready), 72'd0);
    chk("bp_rsp_valid", 72'(rsp_valid), 72'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    #3;
    chk("bp_accept_on_pop", 72'(rsp_valid && (req0_ready || req1_ready)), 72'd1);
    wait_idle("bp_done", 60);
    chk("bp_total", 72'(acc_cnt - s), 72'd6);

    // Reset with three operations in flight: nothing may come out afterwards.
    lat_chk = 1'b1;
    s = acc_cnt;
    q0.push_back('{OP_SINGLE, 18'd5, 18'd5, 18'd0, 18'd0, 72'd25});
    q0.push_back('{OP_SINGLE, 18'd6, 18'd6, 18'd0, 18'd0, 72'd36});
    q0.push_back('{OP_SINGLE, 18'd7, 18'd7, 18'd0, 18'd0, 72'd49});
    for (int n = 0; n < 30 && acc_cnt < s + 3; n++) begin
      @(posedge clk);
      #2;
    end
    chk("rst_inflight_accepts", 72'(acc_cnt - s), 72'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_rsp_valid", 72'(rsp_valid), 72'd0);
    chk("rst_mid_dsp_a0", 72'(dsp_a0), 72'd0);
    chk("rst_mid_dsp_mode", 72'({dsp_mode_1, dsp_mode_0}), 72'd0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("post_rst_rsp_valid", 72'(rsp_valid), 72'd0);
    chk("post_rst_sb_empty", 72'(sb.size()), 72'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
